// File: rtl/bb_sgpio_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bb_sgpio_frame_ctrl_pkg
// Description : Shared types and constants for the baseboard SGPIO frame
//               scheduler: FSM state encoding, per-drive bit offsets inside
//               a frame and default geometry/timing values.
// Revision    : 1.0 - initial release
// ============================================================================
package bb_sgpio_frame_ctrl_pkg;

  // Frame scheduler states; 3 bits leave room for the illegal-state recovery path
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BUILD     = 3'd1,
    ST_OFFER     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_e;

  // Position of each LED inside a drive's 3-bit group
  localparam int c_ofs_act    = 0;
  localparam int c_ofs_locate = 1;
  localparam int c_ofs_fail   = 2;
  localparam int c_bits_per_drive = 3;

  // Default geometry and timing
  localparam int c_def_hdd_num      = 36;
  localparam int c_def_frame_gap    = 1000;
  localparam int c_def_blink_frames = 8;

endpackage : bb_sgpio_frame_ctrl_pkg
`default_nettype wire

// File: rtl/bb_sgpio_led_regs.sv
`default_nettype none
// ============================================================================
// Module      : bb_sgpio_led_regs
// Description : Per-drive LED state: host-written LOCATE/FAIL register file
//               with index decode, plus sticky activity bits that stretch
//               short drive-activity pulses until the next frame build.
// Revision    : 1.0 - initial release
// ============================================================================
module bb_sgpio_led_regs
  import bb_sgpio_frame_ctrl_pkg::*;
#(
  // Drive indices are 8 bits wide, so at most 256 slots are addressable
  parameter int HDD_NUM = c_def_hdd_num
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr_en,
  input  logic [7:0]         i_wr_addr,
  input  logic [1:0]         i_wr_data,
  input  logic [HDD_NUM-1:0] i_drv_act,
  input  logic               i_act_clr,
  output logic [HDD_NUM-1:0] o_locate,
  output logic [HDD_NUM-1:0] o_fail,
  output logic [HDD_NUM-1:0] o_act_sticky
);

  logic [HDD_NUM-1:0] locate_q, locate_d;
  logic [HDD_NUM-1:0] fail_q, fail_d;
  logic [HDD_NUM-1:0] act_sticky_q, act_sticky_d;

  // Write decode: an index at or beyond HDD_NUM matches no slot and is dropped
  always_comb begin
    locate_d = locate_q;
    fail_d   = fail_q;
    for (int i = 0; i < HDD_NUM; i++) begin
      if (i_wr_en && (i_wr_addr == 8'(i))) begin
        locate_d[i] = i_wr_data[0];
        fail_d[i]   = i_wr_data[1];
      end
    end
  end

  // Activity stretch: clearing wins, since a pulse seen during the build
  // cycle is already folded into that frame by the caller
  always_comb begin
    if (i_act_clr) begin
      act_sticky_d = '0;
    end else begin
      act_sticky_d = act_sticky_q | i_drv_act;
    end
  end

  // LED state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locate_q     <= '0;
      fail_q       <= '0;
      act_sticky_q <= '0;
    end else begin
      locate_q     <= locate_d;
      fail_q       <= fail_d;
      act_sticky_q <= act_sticky_d;
    end
  end

  assign o_locate     = locate_q;
  assign o_fail       = fail_q;
  assign o_act_sticky = act_sticky_q;

endmodule : bb_sgpio_led_regs
`default_nettype wire

// File: rtl/bb_sgpio_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bb_sgpio_frame_ctrl
// Description : SGPIO frame scheduler. Builds one ACT/LOCATE/FAIL frame per
//               period, offers it to the shifter over valid/ready, waits for
//               the shift to finish, idles for FRAME_GAP cycles and repeats
//               while ENABLE is high. Also generates the locate blink phase.
// Revision    : 1.0 - initial release
// ============================================================================
module bb_sgpio_frame_ctrl
  import bb_sgpio_frame_ctrl_pkg::*;
#(
  parameter int HDD_NUM      = c_def_hdd_num,
  parameter int FRAME_GAP    = c_def_frame_gap,    // 1 .. 65535
  parameter int BLINK_FRAMES = c_def_blink_frames  // 1 .. 255
) (
  input  logic                                SYSCLK,
  input  logic                                RESET,
  input  logic                                ENABLE,
  input  logic [HDD_NUM-1:0]                  DRV_ACT_LED,
  input  logic                                WR_EN,
  input  logic [7:0]                          WR_ADDR,
  input  logic [1:0]                          WR_DATA,
  output logic [c_bits_per_drive*HDD_NUM-1:0] FRAME_DATA,
  output logic                                FRAME_VALID,
  input  logic                                FRAME_READY,
  input  logic                                SHIFT_DONE,
  output logic                                BUSY,
  output logic [7:0]                          FRAME_CNT
);

  localparam int c_frame_w = c_bits_per_drive * HDD_NUM;

  state_e                 state_q, state_d;
  logic [c_frame_w-1:0]   frame_data_q, frame_data_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   busy_q, busy_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;
  logic [7:0]             blink_cnt_q, blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;
  logic [15:0]            gap_timer_q, gap_timer_d;

  logic                   w_act_clr;
  logic [HDD_NUM-1:0]     w_locate;
  logic [HDD_NUM-1:0]     w_fail;
  logic [HDD_NUM-1:0]     w_act_sticky;
  logic [c_frame_w-1:0]   w_frame;

  bb_sgpio_led_regs #(
    .HDD_NUM (HDD_NUM)
  ) u_led_regs (
    .clk          (SYSCLK),
    .rst          (RESET),
    .i_wr_en      (WR_EN),
    .i_wr_addr    (WR_ADDR),
    .i_wr_data    (WR_DATA),
    .i_drv_act    (DRV_ACT_LED),
    .i_act_clr    (w_act_clr),
    .o_locate     (w_locate),
    .o_fail       (w_fail),
    .o_act_sticky (w_act_sticky)
  );

  // Frame image from current register state. The live activity input is
  // OR-ed in so a pulse landing exactly on the build cycle is not lost when
  // the sticky bits are cleared. FAIL masks ACT; LOCATE follows the blink.
  for (genvar i = 0; i < HDD_NUM; i++) begin : g_drv
    assign w_frame[c_bits_per_drive*i + c_ofs_act] =
      (w_act_sticky[i] | DRV_ACT_LED[i]) & ~w_fail[i];
    assign w_frame[c_bits_per_drive*i + c_ofs_locate] = w_locate[i] & blink_phase_q;
    assign w_frame[c_bits_per_drive*i + c_ofs_fail]   = w_fail[i];
  end

  // Next-state logic for the scheduler, counters and blink generator
  always_comb begin
    state_d       = state_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    frame_cnt_d   = frame_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    gap_timer_d   = gap_timer_q;
    w_act_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ENABLE) begin
          state_d = ST_BUILD;
        end
      end

      ST_BUILD: begin
        frame_data_d  = w_frame;
        frame_valid_d = 1'b1;
        w_act_clr     = 1'b1;
        state_d       = ST_OFFER;
      end

      // Frame is held until accepted; ENABLE is not looked at here
      ST_OFFER: begin
        if (frame_valid_q && FRAME_READY) begin
          frame_valid_d = 1'b0;
          frame_cnt_d   = frame_cnt_q + 8'd1;
          if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = 8'd0;
            blink_phase_d = ~blink_phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (SHIFT_DONE) begin
          gap_timer_d = 16'(FRAME_GAP - 1);
          state_d     = ST_GAP;
        end
      end

      // Timer counts FRAME_GAP-1 down to 0, i.e. FRAME_GAP cycles in GAP
      ST_GAP: begin
        if (gap_timer_q == 16'd0) begin
          state_d = ENABLE ? ST_BUILD : ST_IDLE;
        end else begin
          gap_timer_d = gap_timer_q - 16'd1;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        frame_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Scheduler state and registered outputs; reset aborts any frame in flight
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= 8'd0;
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b0;
      gap_timer_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      gap_timer_q   <= gap_timer_d;
    end
  end

  assign FRAME_DATA  = frame_data_q;
  assign FRAME_VALID = frame_valid_q;
  assign BUSY        = busy_q;
  assign FRAME_CNT   = frame_cnt_q;

endmodule : bb_sgpio_frame_ctrl
`default_nettype wire

// File: tb/tb_bb_sgpio_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bb_sgpio_frame_ctrl
// Description : Self-checking bench for bb_sgpio_frame_ctrl. Stimulus pushes
//               the expected frame into a queue; a monitor pops and compares
//               on every valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bb_sgpio_frame_ctrl;

  localparam int HDD   = 36;
  localparam int FW    = 3 * HDD;
  localparam int GAP   = 20;
  localparam int BLINK = 8;

  logic          SYSCLK = 1'b0;
  logic          RESET  = 1'b1;
  logic          ENABLE = 1'b0;
  logic [HDD-1:0] DRV_ACT_LED = '0;
  logic          WR_EN = 1'b0;
  logic [7:0]    WR_ADDR = 8'd0;
  logic [1:0]    WR_DATA = 2'd0;
  logic [FW-1:0] FRAME_DATA;
  logic          FRAME_VALID;
  logic          FRAME_READY = 1'b1;
  logic          SHIFT_DONE = 1'b0;
  logic          BUSY;
  logic [7:0]    FRAME_CNT;

  int            checks   = 0;
  int            failures = 0;
  logic [FW-1:0] exp_q[$];
  logic [7:0]    acc = 8'd0;

  bb_sgpio_frame_ctrl #(
    .HDD_NUM      (HDD),
    .FRAME_GAP    (GAP),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .SYSCLK      (SYSCLK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .DRV_ACT_LED (DRV_ACT_LED),
    .WR_EN       (WR_EN),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .FRAME_DATA  (FRAME_DATA),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_READY (FRAME_READY),
    .SHIFT_DONE  (SHIFT_DONE),
    .BUSY        (BUSY),
    .FRAME_CNT   (FRAME_CNT)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Expected frame from drive masks and blink phase
  function automatic logic [FW-1:0] mk(input logic [HDD-1:0] act, input logic [HDD-1:0] loc,
                                       input logic [HDD-1:0] fl, input logic ph);
    logic [FW-1:0] e;
    e = '0;
    for (int i = 0; i < HDD; i++) begin
      e[3*i]   = act[i] & ~fl[i];
      e[3*i+1] = loc[i] & ph;
      e[3*i+2] = fl[i];
    end
    return e;
  endfunction

  // Blink phase for a frame built after 'a' accepted frames
  function automatic logic phase_of(input logic [7:0] a);
    return ((int'(a) / BLINK) % 2) == 1;
  endfunction

  // Scoreboard monitor
  always @(negedge SYSCLK) begin
    if (!RESET && FRAME_VALID && FRAME_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=%h required=none", FRAME_DATA);
      end else begin
        chk("frame_data", FRAME_DATA, exp_q.pop_front());
      end
    end
  end

  task automatic pulse_shift_done();
    SHIFT_DONE = 1'b1;
    @(posedge SYSCLK); #1;
    SHIFT_DONE = 1'b0;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [1:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    @(posedge SYSCLK); #1;
    WR_EN = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge SYSCLK);
      n++;
    end while (!FRAME_VALID && n < 300);
    chk("valid_seen", FRAME_VALID, 1'b1);
  endtask

  // One frame: expect it, optionally stall the handshake, then check the count
  task automatic frame(input logic [FW-1:0] e, input int hold);
    logic ok;
    exp_q.push_back(e);
    if (hold > 0) FRAME_READY = 1'b0;
    wait_valid();
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        @(negedge SYSCLK);
        if (!FRAME_VALID || FRAME_DATA !== e || FRAME_CNT !== acc) ok = 1'b0;
      end
      chk("stall_hold", ok, 1'b1);
      @(posedge SYSCLK); #1;
      FRAME_READY = 1'b1;
    end
    @(posedge SYSCLK); #1;
    acc = acc + 8'd1;
    chk("frame_cnt", FRAME_CNT, acc);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HDD-1:0] act_m, loc_m, fail_m, a5;
    logic ok;

    repeat (3) @(posedge SYSCLK);
    #1;
    chk("rst_valid", FRAME_VALID, 1'b0);
    chk("rst_data",  FRAME_DATA, '0);
    chk("rst_busy",  BUSY, 1'b0);
    chk("rst_cnt",   FRAME_CNT, 8'd0);
    RESET = 1'b0;
    @(posedge SYSCLK); #1;

    // First frame: empty, VALID two cycles after ENABLE
    exp_q.push_back('0);
    ENABLE = 1'b1;
    @(posedge SYSCLK); #1;
    chk("lat_valid_1", FRAME_VALID, 1'b0);
    chk("build_busy",  BUSY, 1'b1);
    @(posedge SYSCLK); #1;
    chk("lat_valid_2", FRAME_VALID, 1'b1);
    @(posedge SYSCLK); #1;
    acc = 8'd1;
    chk("cnt_first",  FRAME_CNT, acc);
    chk("valid_drop", FRAME_VALID, 1'b0);

    // Activity pulse on drive 5 stretched into exactly one frame
    DRV_ACT_LED[5] = 1'b1;
    @(posedge SYSCLK); #1;
    DRV_ACT_LED[5] = 1'b0;
    pulse_shift_done();
    a5 = '0; a5[5] = 1'b1;
    frame(mk(a5, '0, '0, 1'b0), 0);
    // Out-of-range index ignored
    host_wr(8'd36, 2'b11);
    pulse_shift_done();
    frame('0, 0);

    // LOCATE/FAIL writes, held activity, blink across two phase changes
    host_wr(8'd3,  2'b11);
    host_wr(8'd0,  2'b10);
    host_wr(8'd7,  2'b01);
    host_wr(8'd35, 2'b01);
    DRV_ACT_LED[3]  = 1'b1;
    DRV_ACT_LED[35] = 1'b1;
    act_m  = '0; act_m[3] = 1'b1; act_m[35] = 1'b1;
    loc_m  = '0; loc_m[3] = 1'b1; loc_m[7] = 1'b1; loc_m[35] = 1'b1;
    fail_m = '0; fail_m[0] = 1'b1; fail_m[3] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      pulse_shift_done();
      frame(mk(act_m, loc_m, fail_m, phase_of(acc)), (k == 5) ? 50 : 0);
    end

    // ENABLE dropped in WAIT_DONE: full gap, then idle
    ENABLE = 1'b0;
    pulse_shift_done();
    ok = 1'b1;
    repeat (GAP - 1) begin
      @(posedge SYSCLK); #1;
      if (!BUSY) ok = 1'b0;
    end
    chk("gap_busy", ok, 1'b1);
    @(posedge SYSCLK); #1;
    chk("idle_busy", BUSY, 1'b0);
    ok = 1'b1;
    repeat (100) begin
      @(negedge SYSCLK);
      if (FRAME_VALID || BUSY) ok = 1'b0;
    end
    chk("idle_quiet", ok, 1'b1);

    // Restart, stall in OFFER, then asynchronous reset mid-frame
    @(posedge SYSCLK); #1;
    ENABLE = 1'b1;
    FRAME_READY = 1'b0;
    wait_valid();
    chk("restart_data", FRAME_DATA, mk(act_m, loc_m, fail_m, phase_of(acc)));
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_valid", FRAME_VALID, 1'b0);
    chk("arst_data",  FRAME_DATA, '0);
    chk("arst_busy",  BUSY, 1'b0);
    chk("arst_cnt",   FRAME_CNT, 8'd0);
    DRV_ACT_LED = '0;
    @(posedge SYSCLK); #1;
    RESET = 1'b0;
    FRAME_READY = 1'b1;
    acc = 8'd0;
    // Registers cleared by reset: next frame is empty
    frame('0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bb_sgpio_frame_ctrl
`default_nettype wire
